// File: rtl/multiplicador_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: state encoding,
// default operand width and the round-robin winner selection.
package multiplicador_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

endpackage

// File: rtl/mult_arb_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting for the multiplier and flags
// the last allowed cycle so the arbiter can abandon the transaction.
module mult_arb_watchdog #(
  parameter int TMO = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count taken in this WAIT cycle would be the TMO-th one.
  assign expired_o = count_i && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/multiplicador_arbitro.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module multiplicador_arbitro
  import multiplicador_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int TMO = 4 * N + 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req0_i,
  input  logic           req1_i,
  input  logic [N-1:0]   a0_i,
  input  logic [N-1:0]   b0_i,
  input  logic [N-1:0]   a1_i,
  input  logic [N-1:0]   b1_i,
  output logic           gnt0_o,
  output logic           gnt1_o,
  output logic           ack0_o,
  output logic           ack1_o,
  output logic [2*N-1:0] p_o,
  output logic           err_o,
  output logic           busy_o,
  output logic           mul_start_o,
  output logic [N-1:0]   mul_a_o,
  output logic [N-1:0]   mul_b_o,
  input  logic           mul_done_i,
  input  logic [2*N-1:0] mul_p_i
);

  state_e         state_q, state_d;
  logic           id_q, id_d;
  logic           last_q, last_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] p_q, p_d;
  logic           winner;

  assign winner = pick_winner(req0_i, req1_i, last_q);

`ifdef MULT_ARB_TIMEOUT_EN
  logic expired;
  logic err_q, err_d;

  mult_arb_watchdog #(
    .TMO(TMO)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == START),
    .count_i  (state_q == WAIT),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
`ifdef MULT_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          id_d    = winner;
          last_d  = winner;
          a_d     = winner ? a1_i : a0_i;
          b_d     = winner ? b1_i : b0_i;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      WAIT: begin
        if (mul_done_i) begin
          p_d     = mul_p_i;
          state_d = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (expired) begin
          p_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign mul_start_o = (state_q == START);
  assign gnt0_o      = (state_q == START) && !id_q;
  assign gnt1_o      = (state_q == START) && id_q;
  assign ack0_o      = (state_q == RESP) && !id_q;
  assign ack1_o      = (state_q == RESP) && id_q;
  assign p_o         = p_q;
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;

endmodule

// File: tb/tb_multiplicador_arbitro.sv
// Self-checking bench for multiplicador_arbitro: a behavioural multiplier
// responder plus a round-robin/product reference model kept in the bench.
module tb_multiplicador_arbitro;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, ack0, ack1;
  logic [7:0] pOut;
  logic       errOut, busy, mulStart;
  logic [3:0] mulA, mulB;
  logic       mulDone;
  logic [7:0] mulP;

  int   checks = 0;
  int   passes = 0;
  int   lastServed = 1;
  int   lat = 4;
  int   cyc = 0;
  int   startCyc = 0;
  bit   running = 1'b0;
  bit   forceDone = 1'b0;
  bit   blockDone = 1'b0;
  logic [7:0] prodQ = '0;

  multiplicador_arbitro dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .req0_i     (req0),
    .req1_i     (req1),
    .a0_i       (a0),
    .b0_i       (b0),
    .a1_i       (a1),
    .b1_i       (b1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .ack0_o     (ack0),
    .ack1_o     (ack1),
    .p_o        (pOut),
    .err_o      (errOut),
    .busy_o     (busy),
    .mul_start_o(mulStart),
    .mul_a_o    (mulA),
    .mul_b_o    (mulB),
    .mul_done_i (mulDone),
    .mul_p_i    (mulP)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: done rises lat cycles after start and stays high (stale) until the next start.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rstN) begin
      running <= 1'b0;
      startCyc <= 0;
      prodQ <= '0;
    end else if (mulStart) begin
      running <= 1'b1;
      startCyc <= cyc;
      prodQ <= 8'(mulA) * 8'(mulB);
    end
  end

  assign mulDone = !blockDone && (forceDone || (running && (cyc >= startCyc + lat)));
  assign mulP = prodQ;

  function automatic int expectWinner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  task automatic waitGrant(input int budget, output int cycles, output int who);
    bit seen = 1'b0;
    who = -1;
    cycles = budget + 1;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        seen = 1'b1;
        cycles = i;
        who = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
      end
    end
  endtask

  task automatic waitAck(input int budget, output int cycles, output int who,
                         output logic [7:0] prod, output logic err);
    bit seen = 1'b0;
    who = -1;
    cycles = budget + 1;
    prod = 'x;
    err = 1'bx;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seen = 1'b1;
        cycles = i;
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        prod = pOut;
        err = errOut;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, ack0, ack1, busy, mulStart, errOut} !== 7'b0) $display("[TB] FAIL reset_ctrl: got %b, expected 0000000", {gnt0, gnt1, ack0, ack1, busy, mulStart, errOut});
    else passes++;
    checks++;
    if ({pOut, mulA, mulB} !== 16'h0) $display("[TB] FAIL reset_data: got %h, expected 0000", {pOut, mulA, mulB});
    else passes++;
    rstN = 1'b1;
    lastServed = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b, expected 0", busy);
    else passes++;
  endtask

  task automatic test_single();
    int cyc0, who; logic [7:0] p; logic e;
    a0 = 4'd13; b0 = 4'd11; lat = 6; req0 = 1'b1;
    waitGrant(4, cyc0, who);
    checks++;
    if (who !== 0 || cyc0 !== 1) $display("[TB] FAIL single_grant: got who=%0d after %0d, expected who=0 after 1", who, cyc0);
    else passes++;
    checks++;
    if ({mulA, mulB, busy} !== {4'd13, 4'd11, 1'b1}) $display("[TB] FAIL single_operands: got a=%0d b=%0d busy=%b, expected 13 11 1", mulA, mulB, busy);
    else passes++;
    lastServed = 0;
    waitAck(lat + 4, cyc0, who, p, e);
    req0 = 1'b0;
    checks++;
    if (who !== 0 || cyc0 !== lat + 1) $display("[TB] FAIL single_ack: got who=%0d after %0d, expected who=0 after %0d", who, cyc0, lat + 1);
    else passes++;
    checks++;
    if (p !== 8'd143 || e !== 1'b0) $display("[TB] FAIL single_result: got p=%0d err=%b, expected p=143 err=0", p, e);
    else passes++;
    @(negedge clk);
    checks++;
    if ({busy, pOut} !== {1'b0, 8'd143}) $display("[TB] FAIL single_hold: got busy=%b p=%0d, expected 0 143", busy, pOut);
    else passes++;
  endtask

  task automatic test_tie();
    int c, who; logic [7:0] p; logic e;
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    lastServed = 1;
    @(negedge clk);
    a0 = 4'd3; b0 = 4'd5; a1 = 4'd7; b1 = 4'd9; lat = 3;
    req0 = 1'b1; req1 = 1'b1;
    waitGrant(4, c, who);
    checks++;
    if (who !== 0 || c !== 1) $display("[TB] FAIL tie_first_grant: got who=%0d after %0d, expected who=0 after 1", who, c);
    else passes++;
    waitAck(lat + 4, c, who, p, e);
    req0 = 1'b0;
    checks++;
    if (who !== 0 || p !== 8'd15) $display("[TB] FAIL tie_first_ack: got who=%0d p=%0d, expected who=0 p=15", who, p);
    else passes++;
    waitGrant(4, c, who);
    checks++;
    if (who !== 1 || c !== 2) $display("[TB] FAIL tie_second_grant: got who=%0d after %0d, expected who=1 after 2", who, c);
    else passes++;
    waitAck(lat + 4, c, who, p, e);
    req1 = 1'b0;
    lastServed = 1;
    checks++;
    if (who !== 1 || p !== 8'd63 || e !== 1'b0) $display("[TB] FAIL tie_second_ack: got who=%0d p=%0d err=%b, expected who=1 p=63 err=0", who, p, e);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int c, who, expWho; logic [7:0] p, expP; logic e;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      lat = $urandom_range(1, 8);
      expWho = expectWinner(1'b1, 1'b1, lastServed);
      expP = (expWho == 1) ? 8'(a1) * 8'(b1) : 8'(a0) * 8'(b0);
      waitGrant(4, c, who);
      checks++;
      if (who !== expWho || c !== ((t == 0) ? 1 : 2)) $display("[TB] FAIL fair_grant%0d: got who=%0d after %0d, expected who=%0d", t, who, c, expWho);
      else passes++;
      lastServed = expWho;
      waitAck(lat + 4, c, who, p, e);
      checks++;
      if (who !== expWho || c !== lat + 1 || p !== expP) $display("[TB] FAIL fair_ack%0d: got who=%0d cyc=%0d p=%0d, expected who=%0d cyc=%0d p=%0d", t, who, c, p, expWho, lat + 1, expP);
      else passes++;
      if (expWho == 1) begin a1 = 4'($urandom); b1 = 4'($urandom); end
      else begin a0 = 4'($urandom); b0 = 4'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int c, who, expWho, n; logic [7:0] p, expP; logic e;
    for (int r = 0; r < 8; r++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      if (!req0 && !req1) req0 = 1'b1;
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      n = int'(req0) + int'(req1);
      for (int j = 0; j < n; j++) begin
        lat = $urandom_range(1, 10);
        expWho = expectWinner(req0, req1, lastServed);
        expP = (expWho == 1) ? 8'(a1) * 8'(b1) : 8'(a0) * 8'(b0);
        waitGrant(4, c, who);
        checks++;
        if (who !== expWho || c !== ((j == 0) ? 1 : 2)) $display("[TB] FAIL rand_grant%0d_%0d: got who=%0d after %0d, expected who=%0d", r, j, who, c, expWho);
        else passes++;
        lastServed = expWho;
        waitAck(lat + 4, c, who, p, e);
        checks++;
        if (who !== expWho || c !== lat + 1 || p !== expP || e !== 1'b0) $display("[TB] FAIL rand_ack%0d_%0d: got who=%0d cyc=%0d p=%0d err=%b, expected who=%0d cyc=%0d p=%0d err=0", r, j, who, c, p, e, expWho, lat + 1, expP);
        else passes++;
        if (expWho == 1) req1 = 1'b0;
        else req0 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stale_done();
    int c, who; logic [7:0] p, expP; logic e;
    forceDone = 1'b1;
    @(negedge clk);
    a0 = 4'($urandom); b0 = 4'($urandom); lat = 8;
    expP = 8'(a0) * 8'(b0);
    req0 = 1'b1;
    waitGrant(4, c, who);
    lastServed = 0;
    waitAck(12, c, who, p, e);
    req0 = 1'b0;
    forceDone = 1'b0;
    checks++;
    if (who !== 0 || c !== 2 || p !== expP) $display("[TB] FAIL stale_done_ack: got who=%0d cyc=%0d p=%0d, expected who=0 cyc=2 p=%0d", who, c, p, expP);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int c, who; logic [7:0] p, expP; logic e;
    a0 = 4'd15; b0 = 4'd14; lat = 10; req0 = 1'b1;
    waitGrant(4, c, who);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, ack0, ack1, busy, mulStart, errOut} !== 7'b0 || {pOut, mulA, mulB} !== 16'h0) $display("[TB] FAIL midreset_clear: got ctrl=%b data=%h, expected all 0", {gnt0, gnt1, ack0, ack1, busy, mulStart, errOut}, {pOut, mulA, mulB});
    else passes++;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy} !== 3'b0) $display("[TB] FAIL midreset_noack: got %b, expected 000", {ack0, ack1, busy});
    else passes++;
    rstN = 1'b1;
    lastServed = 1;
    a0 = 4'($urandom); b0 = 4'($urandom); lat = $urandom_range(1, 6);
    expP = 8'(a0) * 8'(b0);
    waitGrant(4, c, who);
    checks++;
    if (who !== 0 || c !== 1) $display("[TB] FAIL midreset_regrant: got who=%0d after %0d, expected who=0 after 1", who, c);
    else passes++;
    lastServed = 0;
    waitAck(lat + 4, c, who, p, e);
    req0 = 1'b0;
    checks++;
    if (who !== 0 || p !== expP) $display("[TB] FAIL midreset_ack: got who=%0d p=%0d, expected who=0 p=%0d", who, p, expP);
    else passes++;
    @(negedge clk);
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c, who; logic [7:0] p, expP; logic e;
    blockDone = 1'b1;
    a0 = 4'd9; b0 = 4'd9; req0 = 1'b1;
    waitGrant(4, c, who);
    lastServed = 0;
    waitAck(40, c, who, p, e);
    req0 = 1'b0;
    blockDone = 1'b0;
    checks++;
    if (who !== 0 || c !== 25 || p !== 8'd0 || e !== 1'b1) $display("[TB] FAIL timeout_ack: got who=%0d cyc=%0d p=%0d err=%b, expected who=0 cyc=25 p=0 err=1", who, c, p, e);
    else passes++;
    @(negedge clk);
    a1 = 4'($urandom); b1 = 4'($urandom); lat = 5; req1 = 1'b1;
    expP = 8'(a1) * 8'(b1);
    waitGrant(4, c, who);
    lastServed = 1;
    waitAck(lat + 4, c, who, p, e);
    req1 = 1'b0;
    checks++;
    if (who !== 1 || p !== expP || e !== 1'b0) $display("[TB] FAIL timeout_recover: got who=%0d p=%0d err=%b, expected who=1 p=%0d err=0", who, p, e, expP);
    else passes++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_random();
    test_stale_done();
    test_reset_mid_wait();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
